alu_sequencer: RTL and testbench
================================

ALU_SEQUENCER -- requirements
Module: alu_sequencer

Interface
REQ-001 Parameter EXEC_CYCLES, default 1, execute-stage dwell in cycles; legal range 1..15.
REQ-002 CLK  input  1  system clock; all state changes on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 in_data  input  8  command byte stream: opcode, then operand A, then operand B.
REQ-005 in_valid  input  1  in_data valid.
REQ-006 in_ready  output  1  sequencer accepts the byte; a transfer occurs when in_valid && in_ready at a rising edge.
REQ-007 out_data  output  8  result byte, or flag byte when enabled.
REQ-008 out_valid  output  1  out_data valid.
REQ-009 out_ready  input  1  consumer accepts out_data; a transfer occurs when out_valid && out_ready.
REQ-010 busy  output  1  high in every state except IDLE.
REQ-011 err  output  1  one-cycle pulse on an illegal opcode byte.

Function
REQ-012 The FSM SHALL have states IDLE, GET_A, GET_B, EXEC, RESP, plus RESP_F when flags are enabled.
REQ-013 IDLE: in_ready=1; on transfer with in_data[7:3]==0, latch in_data[2:0] as the opcode and go to GET_A.
REQ-014 IDLE: on transfer with in_data[7:3]!=0, pulse err for one cycle, stay in IDLE, and latch nothing.
REQ-015 GET_A / GET_B: in_ready=1; on transfer, latch operand A / B and advance to GET_B / EXEC; with no transfer, hold state indefinitely.
REQ-016 EXEC: in_ready=0; stay EXEC_CYCLES cycles counted by a 4-bit down-counter, then register the result and carry, and enter RESP.
REQ-017 Opcodes SHALL be 0 ADD, 1 SUB (A-B), 2 AND, 3 OR, 4 XOR, 5 NOT A, 6 SHL A by 1, 7 SHR A by 1 (logical); B is ignored for opcodes 5-7.
REQ-018 Widths: result is 8 bits and wraps modulo 256.
REQ-019 Carry SHALL be the ADD carry-out, the SUB borrow (A<B), or the bit shifted out for SHL/SHR; carry is 0 for opcodes 2-5. Zero flag = (result==0).
REQ-020 RESP: out_valid=1 and out_data=result, held stable until out_ready; on transfer go to IDLE (or RESP_F).
REQ-021 in_ready SHALL be 0 in EXEC, RESP, and RESP_F; bytes presented there are not consumed.
REQ-022 Latency: out_valid SHALL rise exactly EXEC_CYCLES edges after the operand-B transfer edge.
REQ-023 Back-to-back: an opcode SHALL be acceptable on the first cycle after the final output transfer, with no other idle cycle.

Reset
REQ-024 While rst=1 (asynchronously): state=IDLE, in_ready=0, out_valid=0, out_data=0x00, busy=0, err=0, and counter and operand registers cleared.
REQ-025 Reset mid-operation SHALL abort the command with no output produced; in_ready=1 on the first cycle after rst falls.

Configuration
REQ-026 Macro ALU_SEQ_FLAGS_EN defined: after the result transfer, enter RESP_F and present out_data={6'b0, carry, zero} with the same handshake, then return to IDLE.
REQ-027 Macro ALU_SEQ_FLAGS_EN undefined: no RESP_F state and no flag storage; a single output beat per command.

Structure
REQ-028 Package alu_seq_pkg SHALL hold the opcode enumeration, the FSM state typedef, and the EXEC_CYCLES bounds.
REQ-029 The combinational datapath SHALL be the sub-module alu_core (a, b, op -> result, carry); alu_sequencer holds only the FSM, counter, and registers.

Verification
REQ-030 Bytes 0x00, 0x09, 0x0A with out_ready=1 -> out_data=0x13 after EXEC_CYCLES edges; flags beat 0x00.
REQ-031 Bytes 0x01, 0x12, 0x1B -> out_data=0xF7; flags beat 0x02 (borrow).
REQ-032 Byte 0x09 in IDLE -> err pulses 1 cycle, state stays IDLE; then 0x06, 0x80, 0x00 -> out_data=0x00, flags 0x03.
REQ-033 out_ready=0 for 5 cycles in RESP -> out_data and out_valid stay stable and in_ready=0; next opcode accepted the cycle after release.
REQ-034 rst asserted in EXEC after 0x02, 0x1B, 0x0A -> out_valid never rises; a following 0x03, 0x09, 0x12 gives 0x1B.
REQ-035 EXEC_CYCLES=15, in_valid gaps between bytes -> result is still correct, and the latency from the B transfer to out_valid is 15 edges.

Source files
------------

// File: rtl/alu_seq_pkg.sv
// Shared types and constants for the ALU command sequencer.
// Optional feature macro: ALU_SEQ_FLAGS_EN (adds a flag beat after each result).
package alu_seq_pkg;

  // Legal range of the execute-stage dwell parameter.
  localparam int unsigned EXEC_CYCLES_MIN = 1;
  localparam int unsigned EXEC_CYCLES_MAX = 15;
  localparam int unsigned CNT_W           = 4;

  typedef enum logic [2:0] {
    OP_ADD = 3'd0,
    OP_SUB = 3'd1,
    OP_AND = 3'd2,
    OP_OR  = 3'd3,
    OP_XOR = 3'd4,
    OP_NOT = 3'd5,
    OP_SHL = 3'd6,
    OP_SHR = 3'd7
  } alu_op_e;

`ifdef ALU_SEQ_FLAGS_EN
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_GET_A  = 3'd1,
    ST_GET_B  = 3'd2,
    ST_EXEC   = 3'd3,
    ST_RESP   = 3'd4,
    ST_RESP_F = 3'd5
  } seq_state_e;
`else
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_GET_A = 3'd1,
    ST_GET_B = 3'd2,
    ST_EXEC  = 3'd3,
    ST_RESP  = 3'd4
  } seq_state_e;
`endif

  // Flag byte layout: bit1 = carry/borrow, bit0 = zero.
  function automatic logic [7:0] flags_byte(input logic carry, input logic [7:0] result);
    return {6'b000000, carry, (result == 8'h00)};
  endfunction

endpackage

// File: rtl/alu_core.sv
// Purely combinational 8-bit ALU: result and carry/borrow/shift-out.
module alu_core
  import alu_seq_pkg::*;
(
  input  logic [7:0] a,
  input  logic [7:0] b,
  input  alu_op_e    op,
  output logic [7:0] result,
  output logic       carry
);

  logic [8:0] wide_s;

  // Evaluate the selected operation; logic ops and NOT never set carry.
  always_comb begin
    result = 8'h00;
    carry  = 1'b0;
    wide_s = 9'h000;
    case (op)
      OP_ADD: begin
        wide_s = {1'b0, a} + {1'b0, b};
        result = wide_s[7:0];
        carry  = wide_s[8];
      end
      OP_SUB: begin
        // Ninth bit of the widened difference is the borrow (a < b).
        wide_s = {1'b0, a} - {1'b0, b};
        result = wide_s[7:0];
        carry  = wide_s[8];
      end
      OP_AND: result = a & b;
      OP_OR:  result = a | b;
      OP_XOR: result = a ^ b;
      OP_NOT: result = ~a;
      OP_SHL: begin
        result = {a[6:0], 1'b0};
        carry  = a[7];
      end
      OP_SHR: begin
        result = {1'b0, a[7:1]};
        carry  = a[0];
      end
      default: begin
        result = 8'h00;
        carry  = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/alu_sequencer.sv
// Byte-stream ALU sequencer: collects opcode, A, B; executes; returns result.
// Optional feature macro: ALU_SEQ_FLAGS_EN (second output beat with {carry, zero}).
module alu_sequencer
  import alu_seq_pkg::*;
#(
  parameter int unsigned EXEC_CYCLES = 1
)(
  input  logic       CLK,
  input  logic       rst,
  input  logic [7:0] in_data,
  input  logic       in_valid,
  output logic       in_ready,
  output logic [7:0] out_data,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       busy,
  output logic       err
);

  // Counter preload: the EXEC state is left when the counter reaches zero.
  localparam logic [CNT_W-1:0] EXEC_LOAD = CNT_W'(EXEC_CYCLES - 1);

  seq_state_e       state_r, state_s;
  logic [CNT_W-1:0] cnt_r;
  alu_op_e          op_r;
  logic [7:0]       a_r, b_r;
  logic [7:0]       out_data_r;
  logic             out_valid_r, busy_r, err_r;
  logic             in_ready_s, in_xfer_s, out_xfer_s, opcode_ok_s, err_s;
  logic [7:0]       core_result_s;
`ifdef ALU_SEQ_FLAGS_EN
  logic             core_carry_s;
  logic             carry_r;
`else
  logic             carry_unused_s;
`endif

  alu_core u_core (
    .a      (a_r),
    .b      (b_r),
    .op     (op_r),
    .result (core_result_s),
`ifdef ALU_SEQ_FLAGS_EN
    .carry  (core_carry_s)
`else
    .carry  (carry_unused_s)
`endif
  );

  // Handshake qualifiers; in_ready is forced low while reset is held.
  always_comb begin
    in_ready_s  = 1'b0;
    if (!rst && (state_r == ST_IDLE || state_r == ST_GET_A || state_r == ST_GET_B)) begin
      in_ready_s = 1'b1;
    end else begin
      in_ready_s = 1'b0;
    end
    in_xfer_s   = in_valid && in_ready_s;
    out_xfer_s  = out_valid_r && out_ready;
    opcode_ok_s = (in_data[7:3] == 5'd0);
    err_s       = (state_r == ST_IDLE) && in_xfer_s && !opcode_ok_s;
  end

  // Next-state logic for the command FSM.
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (in_xfer_s && opcode_ok_s) state_s = ST_GET_A;
        else                          state_s = ST_IDLE;
      end
      ST_GET_A: begin
        if (in_xfer_s) state_s = ST_GET_B;
        else           state_s = ST_GET_A;
      end
      ST_GET_B: begin
        if (in_xfer_s) state_s = ST_EXEC;
        else           state_s = ST_GET_B;
      end
      ST_EXEC: begin
        if (cnt_r == '0) state_s = ST_RESP;
        else             state_s = ST_EXEC;
      end
      ST_RESP: begin
`ifdef ALU_SEQ_FLAGS_EN
        if (out_xfer_s) state_s = ST_RESP_F;
        else            state_s = ST_RESP;
`else
        if (out_xfer_s) state_s = ST_IDLE;
        else            state_s = ST_RESP;
`endif
      end
`ifdef ALU_SEQ_FLAGS_EN
      ST_RESP_F: begin
        if (out_xfer_s) state_s = ST_IDLE;
        else            state_s = ST_RESP_F;
      end
`endif
      default: state_s = ST_IDLE;
    endcase
  end

  // State register plus status outputs registered from the next state.
  always_ff @(posedge CLK or posedge rst) begin
    if (rst) begin
      state_r     <= ST_IDLE;
      busy_r      <= 1'b0;
      out_valid_r <= 1'b0;
      err_r       <= 1'b0;
    end else begin
      state_r     <= state_s;
      busy_r      <= (state_s != ST_IDLE);
`ifdef ALU_SEQ_FLAGS_EN
      out_valid_r <= (state_s == ST_RESP) || (state_s == ST_RESP_F);
`else
      out_valid_r <= (state_s == ST_RESP);
`endif
      err_r       <= err_s;
    end
  end

  // Command capture: opcode, operands, and the execute dwell counter.
  always_ff @(posedge CLK or posedge rst) begin
    if (rst) begin
      op_r  <= OP_ADD;
      a_r   <= 8'h00;
      b_r   <= 8'h00;
      cnt_r <= '0;
    end else begin
      if (state_r == ST_IDLE && in_xfer_s && opcode_ok_s) op_r <= alu_op_e'(in_data[2:0]);
      if (state_r == ST_GET_A && in_xfer_s) a_r <= in_data;
      if (state_r == ST_GET_B && in_xfer_s) begin
        b_r   <= in_data;
        cnt_r <= EXEC_LOAD;
      end else if (state_r == ST_EXEC && cnt_r != '0) begin
        cnt_r <= cnt_r - 1'b1;
      end
    end
  end

  // Output byte: result captured at end of EXEC, then flags (if enabled), then cleared.
  always_ff @(posedge CLK or posedge rst) begin
    if (rst) begin
      out_data_r <= 8'h00;
`ifdef ALU_SEQ_FLAGS_EN
      carry_r    <= 1'b0;
`endif
    end else begin
      if (state_r == ST_EXEC && cnt_r == '0) begin
        out_data_r <= core_result_s;
`ifdef ALU_SEQ_FLAGS_EN
        carry_r    <= core_carry_s;
`endif
      end else if (state_r == ST_RESP && out_xfer_s) begin
`ifdef ALU_SEQ_FLAGS_EN
        out_data_r <= flags_byte(carry_r, out_data_r);
`else
        out_data_r <= 8'h00;
`endif
      end
`ifdef ALU_SEQ_FLAGS_EN
      else if (state_r == ST_RESP_F && out_xfer_s) begin
        out_data_r <= 8'h00;
      end
`endif
    end
  end

  assign in_ready  = in_ready_s;
  assign out_data  = out_data_r;
  assign out_valid = out_valid_r;
  assign busy      = busy_r;
  assign err       = err_r;

endmodule

// File: tb/tb_alu_sequencer.sv
// Directed bench for alu_sequencer: two instances (EXEC_CYCLES=1 and 15),
// scoreboard queue of expected output beats. Honors ALU_SEQ_FLAGS_EN.
module tb_alu_sequencer;

  logic       clk;
  logic       rst;
  logic [7:0] in_data   [2];
  logic       in_valid  [2];
  logic       in_ready  [2];
  logic [7:0] out_data  [2];
  logic       out_valid [2];
  logic       out_ready [2];
  logic       busy      [2];
  logic       err       [2];

  int         checks   = 0;
  int         failures = 0;
  logic [7:0] exp_q[$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  alu_sequencer #(.EXEC_CYCLES(1)) dut (
    .CLK(clk), .rst(rst), .in_data(in_data[0]), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
    .out_data(out_data[0]), .out_valid(out_valid[0]), .out_ready(out_ready[0]),
    .busy(busy[0]), .err(err[0])
  );

  alu_sequencer #(.EXEC_CYCLES(15)) dut15 (
    .CLK(clk), .rst(rst), .in_data(in_data[1]), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
    .out_data(out_data[1]), .out_valid(out_valid[1]), .out_ready(out_ready[1]),
    .busy(busy[1]), .err(err[1])
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Reference model: {carry, result}.
  function automatic logic [8:0] model(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
    int   ai, bi, r;
    logic c;
    ai = int'(a);
    bi = int'(b);
    c  = 1'b0;
    r  = 0;
    case (op)
      3'd0: begin r = ai + bi; c = (r > 255); r = r % 256; end
      3'd1: begin c = (ai < bi); r = (ai - bi + 256) % 256; end
      3'd2: r = int'(a & b);
      3'd3: r = int'(a | b);
      3'd4: r = int'(a ^ b);
      3'd5: r = 255 - ai;
      3'd6: begin c = (ai >= 128); r = (ai * 2) % 256; end
      3'd7: begin c = ((ai % 2) == 1); r = ai / 2; end
      default: r = 0;
    endcase
    return {c, 8'(r)};
  endfunction

  // Drive one byte starting at a negedge; returns at the negedge after its transfer.
  task automatic send_byte(input int sel, input logic [7:0] data, input int gap);
    int n;
    bit done;
    n    = 0;
    done = 1'b0;
    repeat (gap) @(negedge clk);
    in_data[sel]  = data;
    in_valid[sel] = 1'b1;
    while (!done && n < 100) begin
      done = in_ready[sel];
      @(posedge clk);
      @(negedge clk);
      n++;
    end
    in_valid[sel] = 1'b0;
    in_data[sel]  = 8'h00;
    if (!done) check("accept_timeout", 32'd0, 32'd1);
  endtask

  task automatic send_cmd(input int sel, input logic [7:0] opb, input logic [7:0] a,
                          input logic [7:0] b, input int gap);
    logic [8:0] m;
    m = model(opb[2:0], a, b);
    exp_q.push_back(m[7:0]);
`ifdef ALU_SEQ_FLAGS_EN
    exp_q.push_back({6'b000000, m[8], (m[7:0] == 8'h00)});
`endif
    send_byte(sel, opb, gap);
    send_byte(sel, a, gap);
    send_byte(sel, b, gap);
  endtask

  // Wait (bounded) for one output beat, check latency and data, let it transfer.
  task automatic collect(input int sel, input string tag, input int exp_lat);
    int         edges;
    logic [7:0] exp;
    edges = 0;
    while (out_valid[sel] !== 1'b1 && edges < 200) begin
      @(posedge clk);
      edges++;
      @(negedge clk);
    end
    check({tag, "_latency"}, 32'(edges), 32'(exp_lat));
    if (exp_q.size() == 0) begin
      check({tag, "_sb_empty"}, 32'd0, 32'd1);
      exp = 8'hxx;
    end else begin
      exp = exp_q.pop_front();
    end
    check({tag, "_data"}, {24'd0, out_data[sel]}, {24'd0, exp});
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic collect_cmd(input int sel, input string tag, input int exp_lat);
    collect(sel, tag, exp_lat);
`ifdef ALU_SEQ_FLAGS_EN
    collect(sel, {tag, "_flags"}, 0);
`endif
    check({tag, "_ready_after"}, {31'd0, in_ready[sel]}, 32'd1);
    check({tag, "_idle_after"}, {31'd0, busy[sel]}, 32'd0);
  endtask

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    logic [7:0] ra, rb, held;
    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      in_data[i]   = 8'h00;
      in_valid[i]  = 1'b0;
      out_ready[i] = 1'b1;
    end
    repeat (2) @(negedge clk);

    // Reset state.
    check("rst_in_ready",  {31'd0, in_ready[0]},  32'd0);
    check("rst_out_valid", {31'd0, out_valid[0]}, 32'd0);
    check("rst_out_data",  {24'd0, out_data[0]},  32'h00);
    check("rst_busy",      {31'd0, busy[0]},      32'd0);
    check("rst_err",       {31'd0, err[0]},       32'd0);
    rst = 1'b0;
    #1;
    check("rst_release_ready", {31'd0, in_ready[0]}, 32'd1);

    // ADD and SUB examples.
    send_cmd(0, 8'h00, 8'h09, 8'h0A, 0);
    collect_cmd(0, "add", 1);
    send_cmd(0, 8'h01, 8'h12, 8'h1B, 0);
    collect_cmd(0, "sub", 1);

    // Illegal opcode, then SHL with a shifted-out bit and zero result.
    send_byte(0, 8'h09, 0);
    check("err_pulse", {31'd0, err[0]},  32'd1);
    check("err_idle",  {31'd0, busy[0]}, 32'd0);
    check("err_ready", {31'd0, in_ready[0]}, 32'd1);
    @(posedge clk);
    @(negedge clk);
    check("err_one_cycle", {31'd0, err[0]}, 32'd0);
    send_cmd(0, 8'h06, 8'h80, 8'h00, 0);
    collect_cmd(0, "shl", 1);

    // Every opcode with random operands, back to back.
    for (int op = 0; op < 8; op++) begin
      ra = 8'($urandom_range(0, 255));
      rb = 8'($urandom_range(0, 255));
      send_cmd(0, 8'(op), ra, rb, 0);
      collect_cmd(0, $sformatf("op%0d", op), 1);
    end

    // Output stall: data held, no input consumed, then immediate next command.
    out_ready[0] = 1'b0;
    send_cmd(0, 8'h04, 8'h3C, 8'hA5, 0);
    for (int i = 0; i < 20 && out_valid[0] !== 1'b1; i++) begin
      @(posedge clk);
      @(negedge clk);
    end
    held = exp_q[0];
    in_valid[0] = 1'b1;
    in_data[0]  = 8'h00;
    for (int i = 0; i < 5; i++) begin
      check("stall_valid", {31'd0, out_valid[0]}, 32'd1);
      check("stall_data",  {24'd0, out_data[0]},  {24'd0, held});
      check("stall_ready", {31'd0, in_ready[0]},  32'd0);
      @(posedge clk);
      @(negedge clk);
    end
    in_valid[0]  = 1'b0;
    out_ready[0] = 1'b1;
    collect_cmd(0, "stall", 0);
    send_cmd(0, 8'h02, 8'hF0, 8'h3C, 0);
    collect_cmd(0, "post_stall", 1);

    // Reset during EXEC aborts the command.
    send_byte(0, 8'h02, 0);
    send_byte(0, 8'h1B, 0);
    send_byte(0, 8'h0A, 0);
    check("abort_in_exec", {31'd0, busy[0]}, 32'd1);
    rst = 1'b1;
    #1;
    check("abort_valid", {31'd0, out_valid[0]}, 32'd0);
    check("abort_ready", {31'd0, in_ready[0]},  32'd0);
    check("abort_busy",  {31'd0, busy[0]},      32'd0);
    check("abort_data",  {24'd0, out_data[0]},  32'h00);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("abort_release_ready", {31'd0, in_ready[0]}, 32'd1);
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      @(negedge clk);
      check("abort_no_output", {31'd0, out_valid[0]}, 32'd0);
    end
    send_cmd(0, 8'h03, 8'h09, 8'h12, 0);
    collect_cmd(0, "after_abort", 1);

    // Long dwell with gaps between input bytes.
    send_cmd(1, 8'h00, 8'h7F, 8'h81, 3);
    collect_cmd(1, "lat15_add", 15);
    send_cmd(1, 8'h01, 8'h05, 8'h03, 2);
    collect_cmd(1, "lat15_sub", 15);

    check("sb_drained", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
